// File: rtl/gd_pkg.sv
// ============================================================================
// gd_pkg : shared types, mode encodings and saturation helpers for the
//          gradient-descent iteration engine
// Revision: 1.0
// ============================================================================
`default_nettype none

package gd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EVAL_A = 3'd1,
    ST_WAIT_A = 3'd2,
    ST_EVAL_B = 3'd3,
    ST_WAIT_B = 3'd4,
    ST_UPDATE = 3'd5,
    ST_DONE   = 3'd6
  } gd_state_e;

  localparam logic [1:0] MODE_BWD = 2'd0;
  localparam logic [1:0] MODE_CEN = 2'd1;
  localparam logic [1:0] MODE_FWD = 2'd2;

  // Working width for intermediate results; must exceed YW+K+1 and 2*W.
  localparam int SAT_MAXW = 160;

  typedef logic signed [SAT_MAXW-1:0] sat_wide_t;

  typedef struct packed {
    logic      ovf;
    sat_wide_t val;
  } sat_res_t;

  function automatic sat_res_t sat_to(input sat_wide_t v, input int unsigned bits);
    sat_res_t  r;
    sat_wide_t hi;
    sat_wide_t lo;
    hi    = (sat_wide_t'(1) <<< (bits - 1)) - sat_wide_t'(1);
    lo    = ~hi;
    r.ovf = 1'b0;
    r.val = v;
    if (v > hi) begin
      r.val = hi;
      r.ovf = 1'b1;
    end else if (v < lo) begin
      r.val = lo;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

  function automatic sat_res_t sat_w(input sat_wide_t v, input int unsigned w);
    return sat_to(v, w);
  endfunction

  function automatic sat_res_t sat_yw(input sat_wide_t v, input int unsigned yw);
    return sat_to(v, yw);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gd_sat_mult.sv
// ============================================================================
// gd_sat_mult : signed WxW multiply, arithmetic shift by FRAC, saturate to W
// Revision: 1.0
// ============================================================================
`default_nettype none

module gd_sat_mult
  import gd_pkg::*;
#(
  parameter int W    = 32,
  parameter int FRAC = 8
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y,
  output logic                ovf
);

  logic signed [2*W-1:0] w_prod;
  sat_res_t              w_res;
  logic                  w_unused;

  assign w_prod   = (2*W)'(a) * (2*W)'(b);
  assign w_res    = sat_w(sat_wide_t'(w_prod) >>> FRAC, W);
  assign y        = w_res.val[W-1:0];
  assign ovf      = w_res.ovf;
  assign w_unused = ^w_res.val[SAT_MAXW-1:W];

endmodule

`default_nettype wire

// File: rtl/gd_iter_engine.sv
// ============================================================================
// gd_iter_engine : finite-difference gradient descent over one shared,
//                  time-multiplexed function evaluator
// Revision: 1.0
// ============================================================================
`default_nettype none

module gd_iter_engine
  import gd_pkg::*;
#(
  parameter int W    = 32,
  parameter int FRAC = 8,
  parameter int YW   = 64,
  parameter int K    = 8,
  parameter int ITW  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   x0,
  input  logic [W-1:0]   lr,
  input  logic [W-1:0]   tol,
  input  logic [ITW-1:0] max_iter,
  input  logic [1:0]     mode,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   x_out,
  output logic [YW-1:0]  value_out,
  output logic [YW-1:0]  grad_out,
  output logic [ITW-1:0] iter_out,
  output logic           converged,
  output logic           overflow,
  output logic           ev_start,
  output logic [W-1:0]   ev_x,
  input  logic [YW-1:0]  ev_y,
  input  logic           ev_done,
  input  logic           ev_ovf
);

  localparam sat_wide_t C_H  = sat_wide_t'(1) <<< (FRAC - K);
  localparam sat_wide_t C_H2 = C_H <<< 1;

  gd_state_e            r_state;
  gd_state_e            w_state_next;

  logic signed [W-1:0]  r_x;
  logic signed [W-1:0]  r_lr;
  logic [W-1:0]         r_tol;
  logic [ITW-1:0]       r_max_iter;
  logic [ITW-1:0]       r_iter;
  logic [1:0]           r_mode;
  logic signed [YW-1:0] r_ya;
  logic signed [YW-1:0] r_yb;
  logic                 r_conv;
  logic                 r_ovf;
  logic [W-1:0]         r_x_out;
  logic [YW-1:0]        r_grad_out;
  logic [YW-1:0]        r_value_out;

  sat_wide_t            w_off_a;
  sat_wide_t            w_off_b;
  sat_res_t             w_pa_res;
  sat_res_t             w_pb_res;
  sat_res_t             w_grad_res;
  sat_res_t             w_gw_res;
  sat_res_t             w_x_res;
  logic signed [W-1:0]  w_pa;
  logic signed [W-1:0]  w_pb;
  logic signed [W-1:0]  w_g_w;
  logic signed [W-1:0]  w_step;
  logic signed [W-1:0]  w_x_new;
  logic signed [YW-1:0] w_grad;
  logic signed [YW-1:0] w_value;
  logic signed [YW:0]   w_cen_sum;
  logic [W-1:0]         w_abs_step;
  logic [ITW-1:0]       w_iter_inc;
  logic                 w_mul_ovf;
  logic                 w_upd_ovf;
  logic                 w_conv_hit;
  logic                 w_last_iter;
  logic                 w_unused;

  // Sample-point offsets; the reserved mode falls through to backward.
  always_comb begin
    w_off_a = '0;
    w_off_b = '0;
    case (r_mode)
      MODE_CEN: begin
        w_off_a = C_H;
        w_off_b = -C_H;
      end
      MODE_FWD: begin
        w_off_a = C_H2;
        w_off_b = '0;
      end
      default: begin
        w_off_a = '0;
        w_off_b = -C_H2;
      end
    endcase
  end

  assign w_pa_res = sat_w(sat_wide_t'(r_x) + w_off_a, W);
  assign w_pb_res = sat_w(sat_wide_t'(r_x) + w_off_b, W);
  assign w_pa     = w_pa_res.val[W-1:0];
  assign w_pb     = w_pb_res.val[W-1:0];

  assign w_grad_res = sat_yw((sat_wide_t'(r_ya) - sat_wide_t'(r_yb)) <<< (K - 1), YW);
  assign w_grad     = w_grad_res.val[YW-1:0];
  assign w_gw_res   = sat_w(w_grad_res.val, W);
  assign w_g_w      = w_gw_res.val[W-1:0];

  assign w_cen_sum = {r_ya[YW-1], r_ya} + {r_yb[YW-1], r_yb};

  always_comb begin
    w_value = r_ya;
    case (r_mode)
      MODE_CEN: w_value = w_cen_sum[YW:1];
      MODE_FWD: w_value = r_yb;
      default:  w_value = r_ya;
    endcase
  end

  gd_sat_mult #(
    .W    (W),
    .FRAC (FRAC)
  ) u_step_mult (
    .a   (r_lr),
    .b   (w_g_w),
    .y   (w_step),
    .ovf (w_mul_ovf)
  );

  assign w_x_res     = sat_w(sat_wide_t'(r_x) - sat_wide_t'(w_step), W);
  assign w_x_new     = w_x_res.val[W-1:0];
  assign w_upd_ovf   = w_grad_res.ovf | w_gw_res.ovf | w_mul_ovf | w_x_res.ovf;
  // Two's-complement magnitude is exact as unsigned, including the most negative step.
  assign w_abs_step  = w_step[W-1] ? -w_step : w_step;
  assign w_conv_hit  = (w_abs_step < r_tol);
  assign w_iter_inc  = r_iter + ITW'(1);
  assign w_last_iter = w_conv_hit || (w_iter_inc == r_max_iter);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != ST_IDLE);
    done         = 1'b0;
    ev_start     = 1'b0;
    ev_x         = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = (max_iter == '0) ? ST_DONE : ST_EVAL_A;
        end
      end
      ST_EVAL_A: begin
        ev_start     = 1'b1;
        ev_x         = w_pa;
        w_state_next = ST_WAIT_A;
      end
      ST_WAIT_A: begin
        ev_x = w_pa;
        if (ev_done) w_state_next = ST_EVAL_B;
      end
      ST_EVAL_B: begin
        ev_start     = 1'b1;
        ev_x         = w_pb;
        w_state_next = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        ev_x = w_pb;
        if (ev_done) w_state_next = ST_UPDATE;
      end
      ST_UPDATE: begin
        w_state_next = w_last_iter ? ST_DONE : ST_EVAL_A;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x         <= '0;
      r_lr        <= '0;
      r_tol       <= '0;
      r_max_iter  <= '0;
      r_iter      <= '0;
      r_mode      <= '0;
      r_ya        <= '0;
      r_yb        <= '0;
      r_conv      <= 1'b0;
      r_ovf       <= 1'b0;
      r_x_out     <= '0;
      r_grad_out  <= '0;
      r_value_out <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_x         <= x0;
            r_lr        <= lr;
            r_tol       <= tol;
            r_max_iter  <= max_iter;
            r_mode      <= mode;
            r_iter      <= '0;
            r_conv      <= 1'b0;
            r_ovf       <= 1'b0;
            r_x_out     <= (max_iter == '0) ? x0 : '0;
            r_grad_out  <= '0;
            r_value_out <= '0;
          end
        end
        ST_EVAL_A: r_ovf <= r_ovf | w_pa_res.ovf;
        ST_WAIT_A: begin
          if (ev_done) begin
            r_ya  <= ev_y;
            r_ovf <= r_ovf | ev_ovf;
          end
        end
        ST_EVAL_B: r_ovf <= r_ovf | w_pb_res.ovf;
        ST_WAIT_B: begin
          if (ev_done) begin
            r_yb  <= ev_y;
            r_ovf <= r_ovf | ev_ovf;
          end
        end
        ST_UPDATE: begin
          r_x    <= w_x_new;
          r_iter <= w_iter_inc;
          r_ovf  <= r_ovf | w_upd_ovf;
          if (w_last_iter) begin
            r_conv      <= w_conv_hit;
            r_x_out     <= w_x_new;
            r_grad_out  <= w_grad;
            r_value_out <= w_value;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign x_out     = r_x_out;
  assign grad_out  = r_grad_out;
  assign value_out = r_value_out;
  assign iter_out  = r_iter;
  assign converged = r_conv;
  assign overflow  = r_ovf;

  assign w_unused = ^{w_pa_res.val[SAT_MAXW-1:W], w_pb_res.val[SAT_MAXW-1:W],
                      w_gw_res.val[SAT_MAXW-1:W], w_x_res.val[SAT_MAXW-1:W],
                      w_cen_sum[0]};

endmodule

`default_nettype wire

// File: tb/tb_gd_iter_engine.sv
// ============================================================================
// tb_gd_iter_engine : directed vector bench with an f(x) = x*x >> FRAC evaluator
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gd_iter_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] x0;
  logic [31:0] lr;
  logic [31:0] tol;
  logic [7:0]  max_iter;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic [31:0] x_out;
  logic [63:0] value_out;
  logic [63:0] grad_out;
  logic [7:0]  iter_out;
  logic        converged;
  logic        overflow;
  logic        ev_start;
  logic [31:0] ev_x;
  logic [63:0] ev_y;
  logic        ev_done;
  logic        ev_ovf;

  int checks;
  int errors;
  int ev_cnt;
  int fixed_lat;
  bit rand_lat;
  bit spurious;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] x0;
    logic [31:0] lr;
    logic [31:0] tol;
    logic [7:0]  max_iter;
    logic [31:0] e_x;
    logic [63:0] e_grad;
    logic [63:0] e_value;
    logic [7:0]  e_iter;
    logic        e_conv;
    logic        e_ovf;
    int          e_cyc;
  } vec_t;

  vec_t vecs[9];

  gd_iter_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x0        (x0),
    .lr        (lr),
    .tol       (tol),
    .max_iter  (max_iter),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .x_out     (x_out),
    .value_out (value_out),
    .grad_out  (grad_out),
    .iter_out  (iter_out),
    .converged (converged),
    .overflow  (overflow),
    .ev_start  (ev_start),
    .ev_x      (ev_x),
    .ev_y      (ev_y),
    .ev_done   (ev_done),
    .ev_ovf    (ev_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] f_eval(input logic [31:0] x);
    logic signed [63:0] xs;
    xs = {{32{x[31]}}, x};
    return (xs * xs) >>> 8;
  endfunction

  function automatic vec_t mk(input logic [1:0] m, input logic [31:0] x, input logic [31:0] l,
                              input logic [31:0] t, input logic [7:0] mi, input logic [31:0] ex,
                              input logic [63:0] eg, input logic [63:0] ev, input logic [7:0] ei,
                              input logic ec, input logic eo, input int cy);
    vec_t v;
    v.mode = m; v.x0 = x; v.lr = l; v.tol = t; v.max_iter = mi;
    v.e_x = ex; v.e_grad = eg; v.e_value = ev; v.e_iter = ei;
    v.e_conv = ec; v.e_ovf = eo; v.e_cyc = cy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Evaluator model driven on the falling edge; latency counted in WAIT cycles.
  initial begin : evaluator
    int          cnt;
    logic [31:0] px;
    cnt = 0; px = '0;
    ev_done = 1'b0; ev_y = '0; ev_ovf = 1'b0;
    forever begin
      @(negedge clk);
      ev_done = 1'b0;
      ev_y    = '0;
      if (!rst_n) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            ev_done = 1'b1;
            ev_y    = f_eval(px);
          end
        end
        if (ev_start) begin
          px = ev_x;
          ev_cnt++;
          cnt = rand_lat ? int'($urandom_range(1, 20)) : fixed_lat;
          if (spurious && $urandom_range(0, 1) == 1) begin
            ev_done = 1'b1;
            ev_y    = 64'hDEADBEEF_CAFEF00D;
          end
        end
      end
    end
  end

  task automatic run_vec(input int idx, input bit stress);
    vec_t v;
    int   cyc;
    int   ev0;
    v   = vecs[idx];
    ev0 = ev_cnt;
    mode = v.mode; x0 = v.x0; lr = v.lr; tol = v.tol; max_iter = v.max_iter;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk($sformatf("v%0d_s%0d busy_after_start", idx, stress), 64'(busy), 64'd1);
    cyc = 0;
    while (!done && cyc < 3000) begin
      if (stress && busy && $urandom_range(0, 3) == 0) begin
        start = 1'b1; x0 = $urandom; lr = $urandom;
        mode = 2'($urandom_range(0, 3)); max_iter = 8'($urandom_range(0, 255));
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk($sformatf("v%0d_s%0d done_seen", idx, stress), 64'(done), 64'd1);
    chk($sformatf("v%0d_s%0d x_out", idx, stress), 64'(x_out), 64'(v.e_x));
    if (v.max_iter != 8'd0) begin
      chk($sformatf("v%0d_s%0d grad_out", idx, stress), grad_out, v.e_grad);
      chk($sformatf("v%0d_s%0d value_out", idx, stress), value_out, v.e_value);
    end
    chk($sformatf("v%0d_s%0d iter_out", idx, stress), 64'(iter_out), 64'(v.e_iter));
    chk($sformatf("v%0d_s%0d converged", idx, stress), 64'(converged), 64'(v.e_conv));
    chk($sformatf("v%0d_s%0d overflow", idx, stress), 64'(overflow), 64'(v.e_ovf));
    chk($sformatf("v%0d_s%0d ev_starts", idx, stress), 64'(ev_cnt - ev0), 64'(2 * int'(v.e_iter)));
    if (!stress) chk($sformatf("v%0d cycles", idx), 64'(cyc), 64'(v.e_cyc));
    @(posedge clk); #1;
    chk($sformatf("v%0d_s%0d done_busy_drop", idx, stress), 64'({done, busy}), 64'd0);
  endtask

  initial begin : main
    int ev0;
    int n;
    checks = 0; errors = 0; ev_cnt = 0;
    fixed_lat = 1; rand_lat = 1'b0; spurious = 1'b0;
    rst_n = 1'b0; start = 1'b0;
    x0 = '0; lr = '0; tol = '0; max_iter = '0; mode = '0;

    vecs[0] = mk(2'd0, 32'h00000A00, 32'h80, 32'h0,  8'd1,  32'h0, 64'h1400, 64'h6400, 8'd1, 1'b0, 1'b0, 5);
    vecs[1] = mk(2'd1, 32'h00000A00, 32'h80, 32'h0,  8'd1,  32'h0, 64'h1400, 64'h6400, 8'd1, 1'b0, 1'b0, 5);
    vecs[2] = mk(2'd2, 32'h00000A00, 32'h80, 32'h0,  8'd1,  32'h0, 64'h1400, 64'h6400, 8'd1, 1'b0, 1'b0, 5);
    vecs[3] = mk(2'd0, 32'h00000A00, 32'h80, 32'h10, 8'd10, 32'h0, 64'h0,    64'h0,    8'd2, 1'b1, 1'b0, 10);
    vecs[4] = mk(2'd0, 32'h7FFF0000, 32'h7FFFFFFF, 32'h0, 8'd1, 32'hFFFF0001,
                 64'h00000000_FFFE0000, 64'h003FFF00_01000000, 8'd1, 1'b0, 1'b1, 5);
    vecs[5] = mk(2'd3, 32'h00000A00, 32'h80, 32'h0,  8'd1,  32'h0, 64'h1400, 64'h6400, 8'd1, 1'b0, 1'b0, 5);
    vecs[6] = mk(2'd0, 32'h12345678, 32'h80, 32'h0,  8'd0,  32'h12345678, 64'h0, 64'h0, 8'd0, 1'b0, 1'b0, 0);
    vecs[7] = mk(2'd0, 32'hFFFFF600, 32'h80, 32'h0,  8'd1,  32'h0, 64'hFFFFFFFF_FFFFEC00, 64'h6400, 8'd1, 1'b0, 1'b0, 5);
    vecs[8] = mk(2'd0, 32'h00000A00, 32'h40, 32'h0,  8'd2,  32'h280, 64'hA00, 64'h1900, 8'd2, 1'b0, 1'b0, 10);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", 64'({busy, done, ev_start, converged, overflow}), 64'd0);
    chk("reset_data", 64'(x_out | ev_x | 32'(iter_out)) | value_out | grad_out, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(i, 1'b0);

    rand_lat = 1'b1; spurious = 1'b1;
    run_vec(0, 1'b1);
    run_vec(3, 1'b1);
    run_vec(4, 1'b1);
    run_vec(8, 1'b1);
    rand_lat = 1'b0; spurious = 1'b0;

    // Asynchronous reset while parked in WAIT_B.
    fixed_lat = 6;
    ev0 = ev_cnt;
    mode = vecs[8].mode; x0 = vecs[8].x0; lr = vecs[8].lr;
    tol = vecs[8].tol; max_iter = vecs[8].max_iter;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while ((ev_cnt - ev0) < 2 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_reach_eval_b", 64'(ev_cnt - ev0), 64'd2);
    @(posedge clk); #1;
    chk("rst_pre_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ctrl", 64'({busy, done, ev_start, converged, overflow}), 64'd0);
    chk("rst_ev_x", 64'(ev_x), 64'd0);
    chk("rst_data", 64'(x_out | 32'(iter_out)) | value_out | grad_out, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    fixed_lat = 1;
    @(posedge clk); #1;
    chk("rst_idle_after", 64'({busy, done}), 64'd0);
    run_vec(0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
